// File: rtl/sort_store.sv
// Write-back engine: snapshots a wide result vector on store_start and writes it to
// host memory as single-beat AXI4 bursts, most-significant occupied segment first.
module sort_store #(
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 9,
  parameter int PASID_WIDTH  = 9,
  parameter int STORE_WIDTH  = 32768,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      store_start,
  input  logic [ADDR_WIDTH-1:0]     store_start_addr,
  input  logic [PASID_WIDTH-1:0]    store_pasid,
  input  logic [5:0]                store_beat_num,
  input  logic [STORE_WIDTH-1:0]    store_data,
  output logic                      store_done,
  output logic                      store_err,

  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
  output logic [3:0]                m_axi_awcache,
  output logic                      m_axi_awlock,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,

  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,

  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  localparam int MAXB       = STORE_WIDTH / DATA_WIDTH;
  localparam int SEG_W      = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_B, DONE} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [PASID_WIDTH-1:0]   pasid_q;
  logic [STORE_WIDTH-1:0]   data_q;
  logic [5:0]               beats_q;
  logic [5:0]               aw_cnt, w_cnt, b_cnt;
  logic [5:0]               aw_cnt_nxt, w_cnt_nxt, b_cnt_nxt;
  logic [5:0]               beats_clamped;
  logic                     err_q;
  logic                     start_ok, active;
  logic                     awvalid_int, wvalid_int;
  logic                     aw_hs, w_hs, b_hs;
  logic [SEG_W-1:0]         seg;
  logic                     unused_bid;

  assign unused_bid = ^m_axi_bid;

  always_comb begin
    start_ok      = store_start && ((state == IDLE) || (state == DONE));
    beats_clamped = (store_beat_num > 6'(MAXB)) ? 6'(MAXB) : store_beat_num;
    active        = (state == RUN) || (state == WAIT_B);
    // W may only trail AW, so a data beat needs an already-accepted address
    awvalid_int   = (state == RUN) && (aw_cnt < beats_q);
    wvalid_int    = (state == RUN) && (w_cnt < aw_cnt);
    aw_hs         = awvalid_int && m_axi_awready;
    w_hs          = wvalid_int && m_axi_wready;
    b_hs          = m_axi_bvalid && active && (b_cnt < beats_q);
    aw_cnt_nxt    = aw_cnt + {5'd0, aw_hs};
    w_cnt_nxt     = w_cnt + {5'd0, w_hs};
    b_cnt_nxt     = b_cnt + {5'd0, b_hs};
    seg           = SEG_W'(beats_q - 6'd1 - w_cnt);
  end

  // Transitions look at next-cycle counts so a same-cycle final B is not lost
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (store_start) state_nxt = (beats_clamped == 6'd0) ? DONE : RUN;
      end
      RUN: begin
        if ((aw_cnt_nxt == beats_q) && (w_cnt_nxt == beats_q))
          state_nxt = (b_cnt_nxt == beats_q) ? DONE : WAIT_B;
      end
      WAIT_B: begin
        if (b_cnt_nxt == beats_q) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      pasid_q <= '0;
      data_q  <= '0;
      beats_q <= '0;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
      err_q   <= 1'b0;
    end else if (start_ok) begin
      base_q  <= store_start_addr;
      pasid_q <= store_pasid;
      data_q  <= store_data;
      beats_q <= beats_clamped;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
      err_q   <= 1'b0;
    end else begin
      aw_cnt  <= aw_cnt_nxt;
      w_cnt   <= w_cnt_nxt;
      b_cnt   <= b_cnt_nxt;
      if (b_hs && (m_axi_bresp != 2'b00)) err_q <= 1'b1;
    end
  end

  assign store_done     = (state == DONE);
  assign store_err      = err_q;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = base_q + (ADDR_WIDTH'(aw_cnt) << BEAT_SHIFT);
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'(BEAT_SHIFT);
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awuser   = AWUSER_WIDTH'(pasid_q);
  assign m_axi_awcache  = 4'd3;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awvalid  = awvalid_int;

  // Data is gated so the bus reads zero whenever no beat is being offered
  assign m_axi_wdata    = wvalid_int ? data_q[int'(seg) * DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wvalid   = wvalid_int;
  assign m_axi_bready   = 1'b1;

endmodule

// File: doc/sort_store.md
# sort_store

Write-back engine for the hdl_sort action: on `store_start` it snapshots a wide result vector and writes it to host memory as a sequence of single-beat AXI4 write bursts, one DATA_WIDTH beat per burst at consecutive 128-byte addresses. It is the write-direction counterpart of the sort fetch engine and sits between the sort core and the action's AXI master write channels. Segment ordering mirrors the fetch engine's shift-in order, so a fetch→store round trip reproduces memory unchanged.

## Interface
- ID_WIDTH, 1, AXI ID width
- AWUSER_WIDTH, 9, AXI awuser width
- PASID_WIDTH, 9, PASID width (≤ AWUSER_WIDTH, zero-extended)
- STORE_WIDTH, 32768, result vector width; MAXB = STORE_WIDTH/DATA_WIDTH = 32
- DATA_WIDTH, 1024, AXI data width
- ADDR_WIDTH, 64, AXI address width
- Reset is asynchronous and active-low; one clock.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- store_start  in  1  one-cycle start pulse
- store_start_addr  in  ADDR_WIDTH  base byte address, sampled at start
- store_pasid  in  PASID_WIDTH  driven on m_axi_awuser, sampled at start
- store_beat_num  in  6  beats N to write, sampled at start
- store_data  in  STORE_WIDTH  result vector, sampled at start
- store_done  out  1  level: job complete
- store_err  out  1  sticky: a non-OKAY bresp seen in current job
- m_axi_awid/awaddr/awlen/awsize/awburst/awuser/awcache/awlock/awprot/awqos/awregion/awvalid  out  per AXI4
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH; m_axi_wstrb  out  DATA_WIDTH/8; m_axi_wlast, m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  ID_WIDTH; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1

## Operation
- Constants: awid=0, awlen=0, awsize=3'd7, awburst=INCR, awcache=4'd3, awlock=0, awprot=0, awqos=0, awregion=0, wstrb all ones, wlast=1, bready=1.
- States: IDLE, RUN, WAIT_B, DONE. Reset → IDLE.
- store_start in IDLE or DONE: latch addr, pasid, data; N = min(store_beat_num, 32); clear aw_cnt, w_cnt, b_cnt, store_err, store_done; go RUN (N=0 → DONE directly). store_start in RUN/WAIT_B ignored.
- RUN: awvalid = (aw_cnt < N); awaddr = base + aw_cnt*128 (modulo 2^ADDR_WIDTH). aw_cnt++ on awvalid&awready.
- wvalid = (w_cnt < aw_cnt); wdata = latched[(N-1-w_cnt)*DATA_WIDTH +: DATA_WIDTH] (first beat = most-significant occupied segment). w_cnt++ on wvalid&wready. W never leads AW.
- b_cnt++ on bvalid; bresp≠0 sets store_err (bid ignored).
- aw_cnt==N and w_cnt==N → WAIT_B (also taken from RUN if b completes same cycle). b_cnt==N → DONE.
- DONE: store_done=1 until next accepted store_start.
- awvalid/wvalid once asserted hold with stable address/data until handshake.

## Timing
- Reset values: awvalid=0, wvalid=0, store_done=0, store_err=0, awaddr=0, wdata=0, awuser=0; counters 0.
- store_start at cycle 0 → awvalid=1 at cycle 1. With awready=1, wvalid=1 at cycle 2.
- Full-rate (ready always 1, bvalid one cycle after W): one AW and one W per cycle; N beats → store_done at cycle N+3.
- N=0: store_done=1 at cycle 1, no AXI activity.
- store_beat_num > 32 clamps to 32.
- rst_n low mid-job: all valids drop immediately, state IDLE, outstanding responses after reset ignored.
- Simultaneous last W handshake and last bvalid: both counted same cycle.

## Test plan
- N=4, base 0x1000, all ready=1: awaddr 0x1000,0x1080,0x1100,0x1180; wdata = segments 3,2,1,0; store_done at cycle 7; store_err=0.
- N=32, random awready/wready/bvalid delays: exactly 32 AW, 32 W, addresses base+i*128, data segment 31-i, done only after 32nd B.
- N=0: store_done=1 at cycle 1, awvalid/wvalid never asserted.
- N=3, bresp=SLVERR on 2nd response: store_err=1, store_done still asserts after 3rd B; next start clears both.
- store_start pulsed during RUN: ignored, original addresses/data complete; store_beat_num=40 → exactly 32 beats.
- rst_n asserted after 2 of 8 beats: awvalid/wvalid=0 same cycle, outputs at reset values; new start then runs clean.
